// File: rtl/fmul_arbiter_if.sv
// Bundle of request, multiplier and response signals around the shared fp multiplier.
// slave = arbiter side, master = requesters/multiplier/consumer side.
interface fmul_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_REQ-1:0]    i_req_valid;
  logic [32*N_REQ-1:0] i_req_a;
  logic [32*N_REQ-1:0] i_req_b;
  logic [N_REQ-1:0]    o_req_ready;
  logic [31:0]         o_mul_a;
  logic [31:0]         o_mul_b;
  logic [31:0]         i_mul_res;
  logic                o_rsp_valid;
  logic [ID_W-1:0]     o_rsp_id;
  logic [31:0]         o_rsp_res;
  logic                i_rsp_ready;
  logic                o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_mul_res, i_rsp_ready,
    output o_req_ready, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_id, o_rsp_res, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_mul_res, i_rsp_ready,
    input  o_req_ready, o_mul_a, o_mul_b, o_rsp_valid, o_rsp_id, o_rsp_res, o_busy
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one pipelined fp multiplier among N_REQ requesters, with an
// ID tag pipe matched to the multiplier latency and a credit-protected result FIFO.
module fmul_arbiter #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fmul_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0]  tag_id_q [MUL_LAT];
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]  fifo_id_q  [FIFO_DEPTH];
  logic [31:0]      fifo_res_q [FIFO_DEPTH];

  logic             can_issue;
  logic             gnt_vld;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  idx;
  logic             hs;
  logic             push;
  logic             pop;

  // Credit covers both queued results and ops still inside the multiplier.
  assign can_issue = ({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(FIFO_DEPTH);

  // Grant is suppressed while reset is asserted so o_req_ready clears immediately.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    if (can_issue && i_rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        idx = ID_W'((32'(rr_ptr_q) + i) % N_REQ);
        if (!gnt_vld && bus.i_req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx;
        end
      end
    end
  end

  always_comb begin
    bus.o_req_ready = '0;
    bus.o_mul_a     = '0;
    bus.o_mul_b     = '0;
    if (gnt_vld) begin
      bus.o_req_ready[gnt_id] = 1'b1;
      bus.o_mul_a = bus.i_req_a[{gnt_id, 5'b0} +: 32];
      bus.o_mul_b = bus.i_req_b[{gnt_id, 5'b0} +: 32];
    end
  end

  assign hs   = gnt_vld;
  assign push = tag_vld_q[MUL_LAT-1];
  assign pop  = (count_q != '0) && bus.i_rsp_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) rr_ptr_d = ID_W'((32'(gnt_id) + 1) % N_REQ);
  end

  always_comb begin
    inflight_d = inflight_q;
    if (hs && !push)      inflight_d = inflight_q + 1'b1;
    else if (!hs && push) inflight_d = inflight_q - 1'b1;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int unsigned j = 0; j < MUL_LAT; j++) tag_id_q[j] <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= gnt_id;
      for (int unsigned j = 1; j < MUL_LAT; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_id_q[j]  <= tag_id_q[j-1];
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]  <= tag_id_q[MUL_LAT-1];
      fifo_res_q[wr_ptr_q] <= bus.i_mul_res;
    end
  end

  assign bus.o_rsp_valid = (count_q != '0);
  assign bus.o_rsp_id    = fifo_id_q[rd_ptr_q];
  assign bus.o_rsp_res   = fifo_res_q[rd_ptr_q];
  assign bus.o_busy      = (inflight_q != '0) || (count_q != '0);

  a_no_push_when_full: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(push && (count_q == CNT_W'(FIFO_DEPTH)))
  );

endmodule
